irrigation_zone_fsm: RTL and testbench
======================================

Name: irrigation_zone_fsm

Overview:
Parametrised successor to the single-channel operation FSM in the agriculture controller. It sequences irrigation over NZ independent zones that share one pump. Zones are served round-robin, each with a pump-prime delay and a per-zone maximum watering time. It sits after the init FSM: it runs only while the init-busy flag O6 is low and the operating-window input H1 is high. It raises an alarm latch on reservoir loss.

Parameters:
NZ, 4, number of irrigation zones (valid range 2..16)
TPRIME, 3, pump-prime cycles before a valve opens (>=1)
TON_MAX, 8, maximum valve-open cycles per zone visit (>=2)
ZW, $clog2(NZ), zone index width (derived, not overridden)

Ports:
Ck  in  1  clock, rising edge
Clr  in  1  synchronous active-high reset
H1  in  1  irrigation window enable (1 = allowed)
O6  in  1  init busy from init FSM (1 = not ready)
I_dry  in  NZ  per-zone soil-dry sensor (1 = needs water)
I_lvl  in  1  reservoir level OK (1 = OK)
I_rain  in  1  rain detected (1 = inhibit)
O_pump  out  1  pump drive
O_valve  out  NZ  valve drives, at most one bit high (one-hot or zero)
O_zone  out  ZW  zone currently served (valid while O_pump=1)
O_alarm  out  1  reservoir fault latch
O_tmo  out  NZ  sticky per-zone timeout flags (optional feature)

Behaviour:
- Timing model: all state is registered on the rising edge of Ck. Outputs are a Moore decode of the registered state, zone and flags. There are no combinational paths from inputs to outputs.
- Clr: state=IDLE, ptr=0, zone=0, timer=0, O_alarm=0, O_tmo=0. Every output is 0 during reset and in the first cycle after reset.
- Run condition: run = H1 & ~O6 & ~I_rain & I_lvl.
- Priority of events each cycle: Clr, then O6=1, then I_lvl=0, then the normal transitions.
  - O6=1 in any state: go to IDLE, all outputs off; O_alarm is also cleared.
  - I_lvl=0 in PRIME or WATER: go to FAULT.
- States and transitions:
  - IDLE: all off. Go to SCAN when run=1.
  - SCAN: pump off, valves off. Perform a rotating priority search of I_dry, starting at ptr and wrapping mod NZ.
    - Hit: zone <= first hit index, timer <= 0, go to PRIME.
    - No hit, or run=0: go to IDLE.
  - PRIME: O_pump=1, valves off. Timer counts up; when timer == TPRIME-1, go to WATER with timer <= 0. If run=0, go to STOP.
  - WATER: O_pump=1, O_valve[zone]=1, timer increments each cycle. Exit to STOP on the first of:
    - I_dry[zone]=0 (wet);
    - timer == TON_MAX-1 (timeout, giving exactly TON_MAX open cycles);
    - run=0.
  - STOP: single cycle, all off. ptr <= (zone+1) mod NZ, wrapping from NZ-1 to 0. Go to SCAN if run=1, else IDLE.
  - FAULT: all off, O_alarm=1. Leave to IDLE only when I_lvl=1 and H1=0 (operator closes the window to acknowledge); O_alarm clears on that exit.
- Valve count: O_valve is never more than one-hot. A valve is never open while O_pump=0.
- Latency from run rising with one dry zone:
  - SCAN in the next cycle;
  - pump on 2 cycles after run rises;
  - valve on TPRIME cycles after the pump.
- Sensor during SCAN: the dry sensor is sampled only in SCAN and WATER. Zone changes made during PRIME do not abort the visit.
- Timer width is clog2(max(TPRIME,TON_MAX))+1 and the timer never wraps.

Optional Feature:
Macro ZONE_TIMEOUT_FLAG_EN.
- Defined:
  - O_tmo[zone] sets when WATER exits by timeout.
  - It clears when that zone later exits WATER by wet.
  - It is cleared by Clr only, and is unaffected by O6 and FAULT.
- Undefined: O_tmo is tied to 0 and no flag registers are built.

Test Plan:
All scenarios use NZ=4, TPRIME=3, TON_MAX=8. Apply Clr for 2 cycles, then H1=1, O6=0, I_lvl=1, I_rain=0.
1. Single zone, wet exit: I_dry=0100.
   - Pump rises 2 cycles after run.
   - O_valve=0100 and O_zone=2 follow 3 cycles later.
   - Drop I_dry[2] after 4 valve cycles: valve and pump go 0 on the next edge. STOP lasts 1 cycle, then IDLE via SCAN.
2. Timeout: I_dry[1] held at 1.
   - Valve is open exactly 8 cycles, then STOP, then the zone is re-served (ptr=2 wraps back to 1).
   - With ZONE_TIMEOUT_FLAG_EN, O_tmo=0010 after the first visit.
3. Round-robin: I_dry=1001.
   - Serve zone 0 to timeout, then zone 3, then zone 0 again.
   - No zone is served twice in a row while the other is still dry.
4. Reservoir fault: drop I_lvl in WATER.
   - Next edge: pump=0, valves=0, O_alarm=1.
   - Restoring I_lvl with H1=1 keeps FAULT.
   - H1=0 returns to IDLE and sets O_alarm=0.
5. Mid-operation aborts:
   - O6=1 in WATER: IDLE next edge, outputs 0, ptr retained.
   - Clr in WATER: IDLE, ptr=0, O_tmo=0.
6. Rain: I_rain=1 in PRIME leads to STOP then IDLE, and no valve ever opens.

Source files
------------

// File: rtl/irrigation_zone_fsm.sv
// Round-robin irrigation sequencer for NZ zones sharing one pump.
// Each visit primes the pump for TPRIME cycles, then opens one valve for at most
// TON_MAX cycles. It runs only while the init FSM is idle (O6=0) and the window
// (H1) is open. Loss of reservoir level while pumping latches an alarm.
// Optional build macro: ZONE_TIMEOUT_FLAG_EN adds sticky per-zone timeout flags on O_tmo.
module irrigation_zone_fsm #(
  parameter int unsigned NZ      = 4,
  parameter int unsigned TPRIME  = 3,
  parameter int unsigned TON_MAX = 8,
  localparam int unsigned ZW     = $clog2(NZ)
) (
  input  logic          Ck,
  input  logic          Clr,
  input  logic          H1,
  input  logic          O6,
  input  logic [NZ-1:0] I_dry,
  input  logic          I_lvl,
  input  logic          I_rain,
  output logic          O_pump,
  output logic [NZ-1:0] O_valve,
  output logic [ZW-1:0] O_zone,
  output logic          O_alarm,
  output logic [NZ-1:0] O_tmo
);

  localparam int unsigned TMAX = (TPRIME > TON_MAX) ? TPRIME : TON_MAX;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StPrime,
    StWater,
    StStop,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [ZW-1:0]   ptr_q, ptr_d;
  logic [ZW-1:0]   zone_q, zone_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            run;
  logic            hit_found;
  logic [ZW-1:0]   hit_idx;
  int unsigned     scan_cand;
  logic [ZW-1:0]   cand_idx;
  logic            exit_tmo;
  logic            exit_wet;

  assign run = H1 & ~O6 & ~I_rain & I_lvl;

  // Rotating priority search of the dry sensors, starting at ptr and wrapping mod NZ.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    scan_cand = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NZ; i++) begin
      scan_cand = (32'(ptr_q) + i) % NZ;
      cand_idx  = ZW'(scan_cand);
      if (!hit_found && I_dry[cand_idx]) begin
        hit_found = 1'b1;
        hit_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: O6 abort first, then reservoir loss, then normal sequencing.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    zone_d   = zone_q;
    timer_d  = timer_q;
    exit_tmo = 1'b0;
    exit_wet = 1'b0;
    if (O6) begin
      state_d = StIdle;
    end else if (!I_lvl && (state_q == StPrime || state_q == StWater)) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) state_d = StScan;
        end
        StScan: begin
          if (run && hit_found) begin
            zone_d  = hit_idx;
            timer_d = '0;
            state_d = StPrime;
          end else begin
            state_d = StIdle;
          end
        end
        StPrime: begin
          if (!run) begin
            state_d = StStop;
          end else if (timer_q == TW'(TPRIME - 1)) begin
            timer_d = '0;
            state_d = StWater;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StWater: begin
          // Wet wins over a coincident timeout so the flag reflects the soil state.
          if (!I_dry[zone_q]) begin
            exit_wet = 1'b1;
            state_d  = StStop;
          end else if (timer_q == TW'(TON_MAX - 1)) begin
            exit_tmo = 1'b1;
            state_d  = StStop;
          end else if (!run) begin
            state_d = StStop;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StStop: begin
          ptr_d   = (zone_q == ZW'(NZ - 1)) ? '0 : zone_q + ZW'(1);
          state_d = run ? StScan : StIdle;
        end
        StFault: begin
          // Operator acknowledges by closing the window once the level is back.
          if (I_lvl && !H1) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, pointer, zone and timer registers with synchronous clear.
  always_ff @(posedge Ck) begin
    if (Clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      zone_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      zone_q  <= zone_d;
      timer_q <= timer_d;
    end
  end

  // Moore output decode; zone is only presented while the pump runs.
  always_comb begin
    O_pump  = 1'b0;
    O_valve = '0;
    O_zone  = '0;
    O_alarm = 1'b0;
    unique case (state_q)
      StPrime: begin
        O_pump = 1'b1;
        O_zone = zone_q;
      end
      StWater: begin
        O_pump          = 1'b1;
        O_zone          = zone_q;
        O_valve[zone_q] = 1'b1;
      end
      StFault: begin
        O_alarm = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef ZONE_TIMEOUT_FLAG_EN
  logic [NZ-1:0] tmo_q;

  // Sticky timeout flags: set on timeout exit, cleared by a wet exit of that zone or Clr.
  always_ff @(posedge Ck) begin
    if (Clr) begin
      tmo_q <= '0;
    end else if (exit_tmo) begin
      tmo_q[zone_q] <= 1'b1;
    end else if (exit_wet) begin
      tmo_q[zone_q] <= 1'b0;
    end
  end

  assign O_tmo = tmo_q;
`else
  logic unused_exit;
  assign unused_exit = exit_tmo ^ exit_wet;
  assign O_tmo       = '0;
`endif

endmodule

// File: tb/tb_irrigation_zone_fsm.sv
// Directed bench for irrigation_zone_fsm (NZ=4, TPRIME=3, TON_MAX=8).
// Stimulus pushes the expected output word for every clock; a monitor pops and compares.
module tb_irrigation_zone_fsm;

  logic       Ck = 1'b0;
  logic       Clr, H1, O6, I_lvl, I_rain;
  logic [3:0] I_dry;
  logic       O_pump, O_alarm;
  logic [3:0] O_valve, O_tmo;
  logic [1:0] O_zone;

  irrigation_zone_fsm #(
    .NZ(4),
    .TPRIME(3),
    .TON_MAX(8)
  ) dut (
    .Ck(Ck),
    .Clr(Clr),
    .H1(H1),
    .O6(O6),
    .I_dry(I_dry),
    .I_lvl(I_lvl),
    .I_rain(I_rain),
    .O_pump(O_pump),
    .O_valve(O_valve),
    .O_zone(O_zone),
    .O_alarm(O_alarm),
    .O_tmo(O_tmo)
  );

  always #5 Ck = ~Ck;

  typedef struct {
    logic [11:0] v;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [11:0] got;
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  exp_tmo;
  string       tag;
  logic        done = 1'b0;

  // Expected word: {pump, valve[3:0], zone[1:0], alarm, tmo[3:0]}
  function automatic logic [11:0] ev(input logic p, input logic [3:0] v, input logic [1:0] z,
                                     input logic a);
    return {p, v, z, a, exp_tmo};
  endfunction

  task automatic tmo_set(input logic [3:0] m);
`ifdef ZONE_TIMEOUT_FLAG_EN
    exp_tmo = exp_tmo | m;
`else
    exp_tmo = exp_tmo | (m & 4'b0000);
`endif
  endtask

  // Push one expectation per clock edge, then advance past that edge.
  task automatic step(input int n, input logic [11:0] v);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v    = v;
      e.name = tag;
      sb.push_back(e);
      @(posedge Ck);
      #1;
    end
  endtask

  // Monitor: compare the DUT outputs away from the active edge.
  always @(negedge Ck) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      got   = {O_pump, O_valve, O_zone, O_alarm, O_tmo};
      tests++;
      if (got !== mon_e.v) begin
        fails++;
        $display("FAIL %s @%0t: got pump=%b valve=%b zone=%0d alarm=%b tmo=%b, want pump=%b valve=%b zone=%0d alarm=%b tmo=%b",
                 mon_e.name, $time, got[11], got[10:7], got[6:5], got[4], got[3:0],
                 mon_e.v[11], mon_e.v[10:7], mon_e.v[6:5], mon_e.v[4], mon_e.v[3:0]);
      end
    end
    if (done) begin
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    Clr = 1'b1; H1 = 1'b0; O6 = 1'b0; I_lvl = 1'b0; I_rain = 1'b0; I_dry = 4'b0000;
    exp_tmo = 4'b0000;
    tag = "reset";           step(2, ev(0, 4'b0000, 0, 0));

    // 1: single zone, wet exit
    Clr = 1'b0; H1 = 1'b1; I_lvl = 1'b1; I_dry = 4'b0100;
    tag = "s1_scan";         step(1, ev(0, 4'b0000, 0, 0));
    tag = "s1_prime";        step(3, ev(1, 4'b0000, 2, 0));
    tag = "s1_water";        step(4, ev(1, 4'b0100, 2, 0));
    I_dry = 4'b0000;
    tag = "s1_wet_stop";     step(1, ev(0, 4'b0000, 0, 0));
    tag = "s1_idle";         step(2, ev(0, 4'b0000, 0, 0));
    H1 = 1'b0;
    tag = "s1_park";         step(2, ev(0, 4'b0000, 0, 0));

    // 2: timeout and re-serve of the same zone (ptr 3 -> zone 1, then ptr 2 -> zone 1)
    H1 = 1'b1; I_dry = 4'b0010;
    tag = "s2_scan";         step(1, ev(0, 4'b0000, 0, 0));
    tag = "s2_prime";        step(3, ev(1, 4'b0000, 1, 0));
    tag = "s2_water8";       step(8, ev(1, 4'b0010, 1, 0));
    tmo_set(4'b0010);
    tag = "s2_tmo_stop";     step(1, ev(0, 4'b0000, 0, 0));
    tag = "s2_rescan";       step(1, ev(0, 4'b0000, 0, 0));
    tag = "s2_reprime";      step(3, ev(1, 4'b0000, 1, 0));
    tag = "s2_rewater";      step(2, ev(1, 4'b0010, 1, 0));

    // 5a: O6 abort in WATER keeps ptr (=2), so zones 1,2 dry picks zone 2
    O6 = 1'b1;
    tag = "s5_o6_idle";      step(2, ev(0, 4'b0000, 0, 0));
    O6 = 1'b0; I_dry = 4'b0110;
    tag = "s5_o6_scan";      step(1, ev(0, 4'b0000, 0, 0));
    tag = "s5_ptr_kept";     step(3, ev(1, 4'b0000, 2, 0));
    tag = "s5_water";        step(1, ev(1, 4'b0100, 2, 0));

    // 5b: Clr in WATER resets ptr to 0 and the timeout flags
    Clr = 1'b1; exp_tmo = 4'b0000;
    tag = "s5_clr";          step(1, ev(0, 4'b0000, 0, 0));
    Clr = 1'b0;
    tag = "s5_clr_scan";     step(1, ev(0, 4'b0000, 0, 0));
    tag = "s5_ptr_reset";    step(3, ev(1, 4'b0000, 1, 0));
    tag = "s5_clr_water";    step(1, ev(1, 4'b0010, 1, 0));
    H1 = 1'b0;
    tag = "s5_window_close"; step(2, ev(0, 4'b0000, 0, 0));

    // 3: round-robin between zones 0 and 3
    Clr = 1'b1; exp_tmo = 4'b0000;
    tag = "s3_clr";          step(1, ev(0, 4'b0000, 0, 0));
    Clr = 1'b0; H1 = 1'b1; I_dry = 4'b1001;
    tag = "s3_scan0";        step(1, ev(0, 4'b0000, 0, 0));
    tag = "s3_prime0";       step(3, ev(1, 4'b0000, 0, 0));
    tag = "s3_water0";       step(8, ev(1, 4'b0001, 0, 0));
    tmo_set(4'b0001);
    tag = "s3_stop0";        step(1, ev(0, 4'b0000, 0, 0));
    tag = "s3_scan3";        step(1, ev(0, 4'b0000, 0, 0));
    tag = "s3_prime3";       step(3, ev(1, 4'b0000, 3, 0));
    tag = "s3_water3";       step(8, ev(1, 4'b1000, 3, 0));
    tmo_set(4'b1000);
    tag = "s3_stop3";        step(1, ev(0, 4'b0000, 0, 0));
    tag = "s3_scan0b";       step(1, ev(0, 4'b0000, 0, 0));
    tag = "s3_prime0b";      step(3, ev(1, 4'b0000, 0, 0));
    tag = "s3_water0b";      step(1, ev(1, 4'b0001, 0, 0));

    // 4: reservoir fault in WATER
    I_lvl = 1'b0;
    tag = "s4_fault";        step(1, ev(0, 4'b0000, 0, 1));
    I_lvl = 1'b1;
    tag = "s4_hold";         step(2, ev(0, 4'b0000, 0, 1));
    H1 = 1'b0;
    tag = "s4_ack";          step(2, ev(0, 4'b0000, 0, 0));

    // 6: rain during PRIME, no valve opens
    H1 = 1'b1; I_dry = 4'b0100;
    tag = "s6_scan";         step(1, ev(0, 4'b0000, 0, 0));
    tag = "s6_prime";        step(1, ev(1, 4'b0000, 2, 0));
    I_rain = 1'b1;
    tag = "s6_rain_stop";    step(1, ev(0, 4'b0000, 0, 0));
    tag = "s6_rain_idle";    step(4, ev(0, 4'b0000, 0, 0));
    done = 1'b1;
  end

endmodule
